// File: rtl/fetch_stage.sv
// fetch_stage: program counter, PC+4 adder and IF/ID pipeline register with stall/flush.
// Ports: Clk, Reset (async, active-high); Stall, Flush from the hazard unit;
// NextPc from the next-PC mux; InstrIn from instruction memory.
// Outputs are PcOut and combinational PcPlus4, plus the IF/ID fields IfIdInstr, IfIdPcPlus4 and IfIdValid.
// MisalignErr is a sticky error flag and FetchCount counts accepted fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] NextPc,
    input  logic [31:0] InstrIn,
    output logic [31:0] PcOut,
    output logic [31:0] PcPlus4,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPcPlus4,
    output logic        IfIdValid,
    output logic        MisalignErr,
    output logic [31:0] FetchCount
);
    // A flush is a redirect, so it must load the PC even while stalled.
    logic load;
    assign load = Flush | ~Stall;
    assign PcPlus4 = PcOut + 32'd4;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PcOut       <= RESET_PC;
            IfIdInstr   <= '0;
            IfIdPcPlus4 <= '0;
            IfIdValid   <= 1'b0;
            MisalignErr <= 1'b0;
            FetchCount  <= '0;
        end else begin
            if (load) begin
                PcOut <= {NextPc[31:2], 2'b00};
                if (|NextPc[1:0]) MisalignErr <= 1'b1;
            end
            if (Flush) begin
                IfIdInstr   <= '0;
                IfIdPcPlus4 <= '0;
                IfIdValid   <= 1'b0;
            end else if (!Stall) begin
                IfIdInstr   <= InstrIn;
                IfIdPcPlus4 <= PcPlus4;
                IfIdValid   <= 1'b1;
                FetchCount  <= FetchCount + 32'd1;
            end
        end
    end
endmodule
